// File: rtl/mxv_row_engine_pkg.sv
// mxv_row_engine_pkg: shared constants, types and state encoding for the row engine
package mxv_row_engine_pkg;
  localparam int DATA_W = 8;
  localparam int MAX_N = 8;
  localparam int ACC_W = 19;
  localparam int IDX_W = 3;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef logic [3:0] nibble_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, WAIT_RDY, MAC, DONE} state_t;
  function automatic logic n_ok(nibble_t n);
    return (n != 4'd0) && (n <= nibble_t'(MAX_N));
  endfunction
endpackage

// File: rtl/mxv_row_engine_if.sv
// mxv_row_engine_if: M FIFO read side and V register-file read port seen by the engine
interface mxv_row_engine_if;
  import mxv_row_engine_pkg::*;
  logic m_ready;
  logic m_empty;
  data_t m_data;
  logic m_pop;
  idx_t v_addr;
  data_t v_data;
  modport master (input m_ready, m_empty, m_data, v_data, output m_pop, v_addr);
  modport slave (output m_ready, m_empty, m_data, v_data, input m_pop, v_addr);
endinterface

// File: rtl/mxv_row_engine_mac.sv
// mxv_row_engine_mac: unsigned multiply-accumulate with row clear; sum is the running dot product including this cycle's term
module mxv_row_engine_mac
  import mxv_row_engine_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  input  data_t a,
  input  data_t b,
  output acc_t  sum
);
  acc_t acc;
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign sum = acc + ACC_W'(prod);
  // Accumulator: cleared when a row closes, otherwise adds the product on each pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sum;
  end
endmodule

// File: rtl/mxv_row_engine.sv
// mxv_row_engine: pops an N x N matrix row-major from the M FIFO and emits one dot product with V per row
module mxv_row_engine
  import mxv_row_engine_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  nibble_t            N,
  mxv_row_engine_if.master   fifo,
  output acc_t               result,
  output logic               result_valid,
  output idx_t               row_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);
  state_t state;
  nibble_t n_lat;
  idx_t col, row, last;
  logic pop, row_end;
  acc_t sum;
  assign last = idx_t'(n_lat - 4'd1);
  assign pop = (state == MAC) && !fifo.m_empty;
  assign row_end = pop && (col == last);
  assign fifo.m_pop = pop;
  assign fifo.v_addr = col;
  mxv_row_engine_mac u_mac (
    .clk (clk),
    .rst (rst),
    .clr (row_end),
    .en  (pop),
    .a   (fifo.m_data),
    .b   (fifo.v_data),
    .sum (sum)
  );
  // Control FSM with row/column counters and registered status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n_lat <= '0;
      col <= '0;
      row <= '0;
      result <= '0;
      row_idx <= '0;
      result_valid <= FALSE;
      busy <= FALSE;
      done <= FALSE;
      err <= FALSE;
    end else begin
      result_valid <= FALSE;
      done <= FALSE;
      err <= FALSE;
      case (state)
        IDLE: if (start) begin
          if (n_ok(N)) begin
            n_lat <= N;
            busy <= TRUE;
            state <= WAIT_RDY;
          end else err <= TRUE;
        end
        WAIT_RDY: if (fifo.m_ready) state <= MAC;
        MAC: if (pop) begin
          col <= row_end ? '0 : col + 3'd1;
          if (row_end) begin
            result <= sum;
            row_idx <= row;
            result_valid <= TRUE;
            row <= (row == last) ? '0 : row + 3'd1;
            state <= (row == last) ? DONE : MAC;
          end
        end
        DONE: begin
          done <= TRUE;
          busy <= FALSE;
          row <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mxv_row_engine.md
Name: mxv_row_engine

Overview:
- Downstream consumer of the matrix-M FIFO and its push/pop pointer block.
- Waits until the full N×N matrix is loaded, then pops M in row-major order and multiplies each row by vector V held in a register file.
- Emits one dot product per row, then signals done.
- Sits between the M FIFO and the result serializer/output stage of the matrix-vector multiplier.

Parameters:
- DATA_W, 8, width of one M element and one V element (unsigned)
- MAX_N, 8, largest supported matrix dimension
- ACC_W, 19, accumulator/result width; fits MAX_N×(2^DATA_W−1)^2 with no overflow

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a multiply
- N  in  4  matrix dimension (nibble_t); sampled on accepted start
- m_ready  in  1  M FIFO holds exactly N*N pushed elements
- m_empty  in  1  M FIFO empty
- m_data  in  DATA_W  head element of M FIFO; show-ahead, valid while m_empty=0
- m_pop  out  1  consume head element this cycle
- v_addr  out  3  column index into vector register file
- v_data  in  DATA_W  V[v_addr]; combinational read
- result  out  ACC_W  dot product of the most recent row
- result_valid  out  1  one-cycle pulse; result is new
- row_idx  out  3  row number belonging to result
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last row's result
- err  out  1  one-cycle pulse when start is issued with N=0 or N>MAX_N

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; accumulator, column and row counters 0; latched N 0.
- IDLE:
  - start with 1<=N<=MAX_N: latch N, set busy=1, go to WAIT_RDY.
  - start with an invalid N: err pulse next cycle, stay in IDLE.
- WAIT_RDY: hold until m_ready=1, then go to MAC. m_pop stays 0.
- MAC:
  - m_pop = ~m_empty (combinational).
  - v_addr = column counter (col).
  - On each pop: acc <= acc + m_data*v_data; col++.
  - m_empty=1: stall. No pop, acc/col unchanged, no timeout.
  - Pop where col==N_lat−1:
    - register result = acc + product and row_idx = row.
    - next cycle: result_valid=1.
    - acc and col clear to 0.
    - If row==N_lat−1, go to DONE; otherwise row++ and stay in MAC with no bubble.
  - Latency: result_valid is asserted exactly 1 cycle after the pop of the row's last element.
  - result and row_idx hold until the next row result.
- DONE: done=1 for one cycle, busy=0, row clears to 0, return to IDLE. result keeps its last value.
- start while busy: ignored, no err.
- Back-to-back: a start in the cycle after done is accepted normally.
- Arithmetic:
  - Unsigned multiply, DATA_W×DATA_W → 2·DATA_W.
  - Zero-extend into ACC_W; no saturation needed by construction.
- Total pops per run: exactly N_lat², never more. m_pop is never asserted while m_empty=1.
- Reset mid-operation: immediate return to IDLE. A partial accumulation is discarded and no result_valid/done is produced.
- N_lat=1: a single pop produces result and done; result_valid occurs the cycle before done.

Decomposition:
- fifo_pkg gets: DATA_W, MAX_N, ACC_W constants; data_t, acc_t, idx_t typedefs; engine state enum (IDLE, WAIT_RDY, MAC, DONE).
- global_pkg supplies nibble_t and TRUE/FALSE.
- One natural sub-module, mac_unit: registered accumulator with clear/enable, combinational product, and a sum output that feeds result.
- The FSM and the row/col counters stay in the top module.

Test Plan:
- N=2, M=[1 2;3 4] row-major, V=[5 6], m_ready=1, FIFO never empty → result 17 (row 0) then 39 (row 1); 4 pops total; done 1 cycle after the second result_valid.
- N=8, all M=255, all V=255 → eight results of 520200; no overflow; 64 pops.
- N=3, m_empty forced high for 3 cycles mid-row 1 → no pops during the stall; results unchanged vs. the no-stall run; result_valid delayed by exactly 3 cycles.
- start with N=0, then N=9 → err pulse each time; busy stays 0; no m_pop.
- N=2, m_ready held 0 for 10 cycles after start → no m_pop until m_ready rises; then normal results.
- rst asserted after the first pop of row 1 (N=3) → all outputs 0 asynchronously; a new start after release with a fresh FIFO gives correct results.
